// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-RAM arbiter, its two requesters and the RAM.
// p1_lock is present only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             p0_req;
    logic             p0_we;
    logic [WIDTH-1:0] p0_addr;
    logic [WIDTH-1:0] p0_wdata;
    logic             p0_gnt;
    logic [WIDTH-1:0] p0_rdata;
    logic             p0_rvalid;

    logic             p1_req;
    logic             p1_we;
    logic [WIDTH-1:0] p1_addr;
    logic [WIDTH-1:0] p1_wdata;
    logic             p1_gnt;
    logic [WIDTH-1:0] p1_rdata;
    logic             p1_rvalid;
`ifdef DMEM_ARB_LOCK_EN
    logic             p1_lock;
`endif

    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rdata, p0_rvalid,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rdata, p1_rvalid,
`ifdef DMEM_ARB_LOCK_EN
        input  p1_lock,
`endif
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rdata, p0_rvalid,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rdata, p1_rvalid,
`ifdef DMEM_ARB_LOCK_EN
        output p1_lock,
`endif
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: port 0 has priority, port 1 is
// protected by an anti-starvation counter. Optional atomic lock for port 1: DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e           state_q, state_d;
    logic [3:0]       starve_q, starve_d;
    logic             gnt0_s, gnt1_s, lock_s;
    logic             rd0_s, rd1_s;
    logic [WIDTH-1:0] mem_addr_s, mem_wdata_s;
    logic             mem_we_s;
    logic [WIDTH-1:0] p0_rdata_q, p1_rdata_q;
    logic             p0_rvalid_q, p1_rvalid_q;

`ifdef DMEM_ARB_LOCK_EN
    assign lock_s = (state_q == OWN1) && bus.p1_lock && bus.p1_req;
`else
    // Last-owner state only steers the lock; kept for observability in this build.
    logic unused_state_s;
    assign lock_s         = 1'b0;
    assign unused_state_s = ^state_q;
`endif

    // Grant selection: lock, then starvation relief, then port-0 priority.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (lock_s) begin
            gnt1_s = 1'b1;
        end else if (bus.p0_req && bus.p1_req) begin
            if (starve_q == LIMIT) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (bus.p0_req) begin
            gnt0_s = 1'b1;
        end else if (bus.p1_req) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // RAM mux: granted port drives the RAM, zeros when idle.
    always_comb begin
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        mem_we_s    = 1'b0;
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                mem_addr_s  = bus.p0_addr;
                mem_wdata_s = bus.p0_wdata;
                mem_we_s    = bus.p0_we;
            end
            2'b10: begin
                mem_addr_s  = bus.p1_addr;
                mem_wdata_s = bus.p1_wdata;
                mem_we_s    = bus.p1_we;
            end
            default: begin
                mem_addr_s  = '0;
                mem_wdata_s = '0;
                mem_we_s    = 1'b0;
            end
        endcase
    end

    // Next owner state and starvation counter (saturating, cleared once port 1 is served or idle).
    always_comb begin
        state_d  = IDLE;
        starve_d = starve_q;
        if (gnt0_s) begin
            state_d = OWN0;
        end else if (gnt1_s) begin
            state_d = OWN1;
        end else begin
            state_d = IDLE;
        end
        if (gnt1_s || !bus.p1_req) begin
            starve_d = 4'd0;
        end else if (gnt0_s && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    assign rd0_s = gnt0_s && !bus.p0_we;
    assign rd1_s = gnt1_s && !bus.p1_we;

    // Owner FSM, counter and registered read-return path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            p0_rvalid_q <= rd0_s;
            p1_rvalid_q <= rd1_s;
            if (rd0_s) begin
                p0_rdata_q <= bus.mem_rdata;
            end else begin
                p0_rdata_q <= p0_rdata_q;
            end
            if (rd1_s) begin
                p1_rdata_q <= bus.mem_rdata;
            end else begin
                p1_rdata_q <= p1_rdata_q;
            end
        end
    end

    assign bus.p0_gnt    = gnt0_s;
    assign bus.p1_gnt    = gnt1_s;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.mem_we    = mem_we_s;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a behavioural model
// of priority, starvation relief and a word-addressed memory.
module tb_dmem_arbiter;
    localparam int W     = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.WIDTH(W)) bus();
    dmem_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // 256-word RAM; upper address bits are ignored by the RAM.
    logic [W-1:0] ram [0:255];
    assign bus.mem_rdata = ram[bus.mem_addr[7:0]];
    always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;

    typedef struct packed {
        logic         g0;
        logic         g1;
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic         rv0;
        logic [W-1:0] rd0;
        logic         rv1;
        logic [W-1:0] rd1;
    } obs_t;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] mm [0:255];
    int           m_waits;   // consecutive port-0 wins while port 1 waited
    int           m_owner;   // -1 none, 0, 1
    logic         m_rv0, m_rv1;
    logic [W-1:0] m_rd0, m_rd1;

    task automatic model_reset();
        m_waits = 0; m_owner = -1;
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
        bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
        bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    endtask

    // One clock: predict from the model, sample combinational outputs at negedge, registered after posedge.
    task automatic cycle(output obs_t o, output obs_t e);
        int   g;
        logic r0, r1;
        r0 = bus.p0_req; r1 = bus.p1_req;
        g  = -1;
        if (r0 && r1)  g = (m_waits >= LIMIT) ? 1 : 0;
        else if (r0)   g = 0;
        else if (r1)   g = 1;
`ifdef DMEM_ARB_LOCK_EN
        if (m_owner == 1 && bus.p1_lock && r1) g = 1;
`endif
        e = '0;
        e.g0 = (g == 0);
        e.g1 = (g == 1);
        if (g == 0) begin
            e.we = bus.p0_we; e.addr = bus.p0_addr; e.wdata = bus.p0_wdata;
        end else if (g == 1) begin
            e.we = bus.p1_we; e.addr = bus.p1_addr; e.wdata = bus.p1_wdata;
        end
        if (g == 0 && r1) m_waits = (m_waits < LIMIT) ? m_waits + 1 : LIMIT;
        else              m_waits = 0;
        m_owner = g;
        m_rv0 = (g == 0) && !e.we;
        m_rv1 = (g == 1) && !e.we;
        if (m_rv0) m_rd0 = mm[e.addr[7:0]];
        if (m_rv1) m_rd1 = mm[e.addr[7:0]];
        if (g >= 0 && e.we) mm[e.addr[7:0]] = e.wdata;
        e.rv0 = m_rv0; e.rd0 = m_rd0; e.rv1 = m_rv1; e.rd1 = m_rd1;

        @(negedge clk);
        o.g0 = bus.p0_gnt; o.g1 = bus.p1_gnt; o.we = bus.mem_we;
        o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
        @(posedge clk);
        #1;
        o.rv0 = bus.p0_rvalid; o.rd0 = bus.p0_rdata;
        o.rv1 = bus.p1_rvalid; o.rd1 = bus.p1_rdata;
    endtask

    task automatic test_reset();
        obs_t o, e;
        rst_n = 1'b0;
        set_p0(1'b1, 1'b1, 32'd9, 32'h0000_0055);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.p0_gnt, bus.p1_gnt} !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b exp 00", {bus.p0_gnt, bus.p1_gnt}); end
        total++;
        if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b exp 0", bus.mem_we); end
        total++;
        if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b0, 32'd0}) begin bad++; $display("FAIL rst_p0: got %b/%h exp 0/0", bus.p0_rvalid, bus.p0_rdata); end
        total++;
        if ({bus.p1_rvalid, bus.p1_rdata} !== {1'b0, 32'd0}) begin bad++; $display("FAIL rst_p1: got %b/%h exp 0/0", bus.p1_rvalid, bus.p1_rdata); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL rst_release: got %h exp %h", o, e); end
        total++;
        if (o.g0 !== 1'b1) begin bad++; $display("FAIL rst_release_gnt: got %b exp 1", o.g0); end
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        cycle(o, e);
    endtask

    task automatic test_write_read();
        obs_t o, e;
        set_p0(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
        cycle(o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL wr: got %h exp %h", o, e); end
        set_p0(1'b1, 1'b0, 32'd5, 32'd0);
        cycle(o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL rd: got %h exp %h", o, e); end
        total++;
        if ({o.rv0, o.rd0} !== {1'b1, 32'hDEAD_BEEF}) begin bad++; $display("FAIL rd_data: got %b/%h exp 1/deadbeef", o.rv0, o.rd0); end
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        cycle(o, e);
        total++;
        if ({o.rv0, o.rd0} !== {1'b0, 32'hDEAD_BEEF}) begin bad++; $display("FAIL rd_hold: got %b/%h exp 0/deadbeef", o.rv0, o.rd0); end
    endtask

    task automatic test_starvation();
        obs_t o, e;
        logic pat [12];
        pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            set_p0(1'b1, 1'b1, 32'(20 + i), $urandom);
            set_p1(1'b1, 1'b0, 32'd5, 32'd0);
            cycle(o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL starve_model[%0d]: got %h exp %h", i, o, e); end
            total++;
            if (o.g1 !== pat[i]) begin bad++; $display("FAIL starve_pat[%0d]: got %b exp %b", i, o.g1, pat[i]); end
        end
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        cycle(o, e);
    endtask

    task automatic test_untruncated_addr();
        obs_t o, e;
        set_p0(1'b1, 1'b1, 32'h104, 32'd7);
        cycle(o, e);
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b1, 1'b0, 32'h104, 32'd0);
        cycle(o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL p1_rd: got %h exp %h", o, e); end
        total++;
        if ({o.addr, o.rv1, o.rd1, o.rv0} !== {32'h104, 1'b1, 32'd7, 1'b0}) begin
            bad++; $display("FAIL p1_rd_fields: got %h/%b/%h/%b exp 104/1/7/0", o.addr, o.rv1, o.rd1, o.rv0);
        end
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        cycle(o, e);
    endtask

    task automatic test_same_addr();
        obs_t o, e;
        set_p1(1'b1, 1'b1, 32'd3, 32'h22);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_p0(1'b1, 1'b0, 32'd8, 32'd0);
            else       set_p0(1'b1, 1'b1, 32'd3, 32'h11);
            cycle(o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL same_model[%0d]: got %h exp %h", i, o, e); end
        end
        total++;
        if (o.g1 !== 1'b1) begin bad++; $display("FAIL same_p1_wins: got %b exp 1", o.g1); end
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        set_p0(1'b1, 1'b0, 32'd3, 32'd0);
        cycle(o, e);
        total++;
        if (o.rd0 !== 32'h22) begin bad++; $display("FAIL same_rd_p1data: got %h exp 22", o.rd0); end
        set_p0(1'b1, 1'b1, 32'd3, 32'h11);
        cycle(o, e);
        set_p0(1'b1, 1'b0, 32'd3, 32'd0);
        cycle(o, e);
        total++;
        if (o.rd0 !== 32'h11) begin bad++; $display("FAIL same_rd_p0data: got %h exp 11", o.rd0); end
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        cycle(o, e);
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        set_p0(1'b1, 1'b0, 32'd3, 32'd0);
        cycle(o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL mid_rd: got %h exp %h", o, e); end
        rst_n = 1'b0;
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b1, 1'b1, 32'd3, 32'h99);
        #1;
        total++;
        if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b0, 32'd0}) begin bad++; $display("FAIL mid_rvalid: got %b/%h exp 0/0", bus.p0_rvalid, bus.p0_rdata); end
        @(negedge clk);
        total++;
        if ({bus.mem_we, bus.p1_gnt} !== 2'b00) begin bad++; $display("FAIL mid_we: got %b exp 00", {bus.mem_we, bus.p1_gnt}); end
        @(posedge clk);
        #1;
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;
        model_reset();
        set_p0(1'b1, 1'b0, 32'd3, 32'd0);
        cycle(o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL mid_after: got %h exp %h", o, e); end
        total++;
        if (o.rd0 !== 32'h11) begin bad++; $display("FAIL mid_no_write: got %h exp 11", o.rd0); end
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        cycle(o, e);
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        obs_t o, e;
        set_p1(1'b1, 1'b0, 32'd3, 32'd0);
        bus.p1_lock = 1'b1;
        cycle(o, e);
        for (int i = 0; i < 3; i++) begin
            set_p0(1'b1, 1'b0, 32'd5, 32'd0);
            cycle(o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL lock_model[%0d]: got %h exp %h", i, o, e); end
            total++;
            if ({o.g0, o.g1} !== 2'b01) begin bad++; $display("FAIL lock_hold[%0d]: got %b exp 01", i, {o.g0, o.g1}); end
        end
        bus.p1_lock = 1'b0;
        cycle(o, e);
        total++;
        if (o.g0 !== 1'b1) begin bad++; $display("FAIL lock_release: got %b exp 1", o.g0); end
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        cycle(o, e);
    endtask
`endif

    task automatic test_random();
        obs_t o, e;
        for (int i = 0; i < 400; i++) begin
            set_p0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
            set_p1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
`ifdef DMEM_ARB_LOCK_EN
            bus.p1_lock = 1'($urandom_range(0, 1));
`endif
            cycle(o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL random[%0d]: got %h exp %h", i, o, e); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = '0;
            mm[i]  = '0;
        end
        model_reset();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
`ifdef DMEM_ARB_LOCK_EN
        bus.p1_lock = 1'b0;
`endif
        test_reset();
        test_write_read();
        test_starvation();
        test_untruncated_addr();
        test_same_addr();
        test_reset_mid();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
